// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider: Start/Done handshake,
// operands in, registered results and status flags out.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             ovf;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, ovf
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, with optional
// two's-complement operands handled as magnitudes plus a sign fixup step.
module seq_divider #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state, state_next;
  logic             start_q;
  logic             accept;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, ovf_case;
  logic [WIDTH-1:0] quotient, remainder;
  logic             dbz, ovf;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   p_shift, p_sub;
  logic             fits;
  logic             is_ovf;

  // Magnitudes of the most-negative value wrap to itself, which is still the
  // correct unsigned magnitude in WIDTH bits.
  assign dvd_neg = SIGNED ? bus.dividend[WIDTH-1] : 1'b0;
  assign dvs_neg = SIGNED ? bus.divisor[WIDTH-1]  : 1'b0;
  assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
  assign dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;
  assign is_ovf  = SIGNED && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                          && (bus.divisor == '1);

  assign p_shift = {p, q[WIDTH-1]};
  assign p_sub   = p_shift - {1'b0, dvsr};
  assign fits    = (p_shift >= {1'b0, dvsr});

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start && !start_q) begin
          accept     = 1'b1;
          state_next = (bus.divisor == '0) ? DONE : CALC;
        end
      end
      CALC:    if (cnt == CW'(WIDTH - 1)) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // start_q resets high so a Start held through reset release is not a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b1;
    end else begin
      state   <= state_next;
      start_q <= bus.start;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= '0;
      q         <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf_case  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      if (bus.divisor == '0) begin
        quotient  <= '1;
        remainder <= bus.dividend;
        dbz       <= 1'b1;
        ovf       <= 1'b0;
      end else begin
        p        <= '0;
        q        <= dvd_mag;
        dvsr     <= dvs_mag;
        cnt      <= '0;
        neg_q    <= dvd_neg ^ dvs_neg;
        neg_r    <= dvd_neg;
        ovf_case <= is_ovf;
        dbz      <= 1'b0;
        ovf      <= 1'b0;
      end
    end else if (state == CALC) begin
      p   <= fits ? p_sub[WIDTH-1:0] : p_shift[WIDTH-1:0];
      q   <= {q[WIDTH-2:0], fits};
      cnt <= cnt + 1'b1;
    end else if (state == FIXUP) begin
      if (ovf_case) begin
        quotient  <= {1'b1, {(WIDTH-1){1'b0}}};
        remainder <= '0;
        ovf       <= 1'b1;
      end else begin
        quotient  <= neg_q ? -q : q;
        remainder <= neg_r ? -p : p;
      end
    end
  end

  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.busy        = (state == CALC) || (state == FIXUP);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz;
  assign bus.ovf         = ovf;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a signed and an unsigned instance share clock and
// reset; results are compared against plain integer division.
module tb_seq_divider;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_divider_if #(.WIDTH(8)) bus_s ();
  seq_divider_if #(.WIDTH(8)) bus_u ();

  seq_divider #(.WIDTH(8), .SIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  seq_divider #(.WIDTH(8), .SIGNED(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void model(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output bit dz, output bit ov);
    int sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 8'h00) begin
      q  = 8'hFF;
      r  = a;
      dz = 1'b1;
    end else if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        q  = 8'h80;
        r  = 8'h00;
        ov = 1'b1;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
    end else begin
      q = 8'(int'(a) / int'(b));
      r = 8'(int'(a) % int'(b));
    end
  endfunction

  task automatic drive(input bit sel, input logic st, input logic [7:0] a, input logic [7:0] b);
    if (sel) begin
      bus_s.start = st; bus_s.dividend = a; bus_s.divisor = b;
    end else begin
      bus_u.start = st; bus_u.dividend = a; bus_u.divisor = b;
    end
  endtask

  task automatic sample(input bit sel, output logic [7:0] q, output logic [7:0] r,
                        output logic busy, output logic done, output logic dz, output logic ov);
    if (sel) begin
      q = bus_s.quotient; r = bus_s.remainder; busy = bus_s.busy;
      done = bus_s.done; dz = bus_s.div_by_zero; ov = bus_s.ovf;
    end else begin
      q = bus_u.quotient; r = bus_u.remainder; busy = bus_u.busy;
      done = bus_u.done; dz = bus_u.div_by_zero; ov = bus_u.ovf;
    end
  endtask

  // Pulses Start and reports the index of the edge after which Done was seen
  // (accepting edge = 0), or -1 if it never came.
  task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                       output int last_edge, output int busy_cnt);
    logic [7:0] q, r;
    logic busy, done, dz, ov;
    @(negedge clk);
    drive(sel, 1'b1, a, b);
    @(posedge clk);
    last_edge = -1;
    busy_cnt  = 0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (e == 0) drive(sel, 1'b0, a, b);
      sample(sel, q, r, busy, done, dz, ov);
      if (done) begin
        last_edge = e;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    logic [7:0] q, r;
    logic busy, done, dz, ov;
    for (int s = 0; s < 2; s++) begin
      sample(s[0], q, r, busy, done, dz, ov);
      checks++;
      if ({q, r, busy, done, dz, ov} !== 20'h0) begin
        errors++;
        $display("[TB] FAIL reset_state sel=%0d got %h want %h", s, {q, r, busy, done, dz, ov}, 20'h0);
      end
    end
  endtask

  task automatic check_op(input string name, input bit sel, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q, r, eq, er;
    logic busy, done, dz, ov;
    bit edz, eov;
    int last_edge, busy_cnt;
    model(sel, a, b, eq, er, edz, eov);
    do_op(sel, a, b, last_edge, busy_cnt);
    sample(sel, q, r, busy, done, dz, ov);
    checks++;
    if ({q, r, dz, ov} !== {eq, er, edz, eov}) begin
      errors++;
      $display("[TB] FAIL %s result %h/%h got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
               name, a, b, q, r, dz, ov, eq, er, edz, eov);
    end
    checks++;
    if (last_edge !== (edz ? 0 : 9) || busy_cnt !== (edz ? 0 : 9)) begin
      errors++;
      $display("[TB] FAIL %s timing got done_edge=%0d busy=%0d want done_edge=%0d busy=%0d",
               name, last_edge, busy_cnt, edz ? 0 : 9, edz ? 0 : 9);
    end
  endtask

  task automatic test_basic();
    check_op("basic_100_7", 1'b1, 8'd100, 8'd7);
  endtask

  task automatic test_signs();
    check_op("neg_dividend", 1'b1, 8'h9C, 8'd7);
    check_op("neg_divisor",  1'b1, 8'd100, 8'hF9);
    check_op("both_neg",     1'b1, 8'h9C, 8'hF9);
  endtask

  task automatic test_div_zero();
    check_op("div_zero", 1'b1, 8'h55, 8'h00);
    check_op("clear_dz", 1'b1, 8'd100, 8'd7);
    check_op("div_zero_u", 1'b0, 8'hA3, 8'h00);
  endtask

  task automatic test_overflow();
    check_op("signed_ovf", 1'b1, 8'h80, 8'hFF);
    check_op("unsigned_ff_10", 1'b0, 8'hFF, 8'h10);
    check_op("unsigned_big", 1'b0, 8'hF0, 8'hFF);
  endtask

  task automatic test_reset_mid();
    logic [7:0] q, r;
    logic busy, done, dz, ov;
    @(negedge clk);
    drive(1'b1, 1'b1, 8'd100, 8'd7);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 sample(1'b1, q, r, busy, done, dz, ov);
    checks++;
    if ({q, r, busy, done, dz, ov} !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid got %h want %h", {q, r, busy, done, dz, ov}, 20'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample(1'b1, q, r, busy, done, dz, ov);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL held_start_after_reset got busy/done=%b want 00", {busy, done});
    end
    drive(1'b1, 1'b0, 8'd100, 8'd7);
    check_op("after_reset_op", 1'b1, 8'd50, 8'd5);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, r;
    logic busy, done, dz, ov;
    int last_edge;
    @(negedge clk);
    drive(1'b1, 1'b1, 8'd100, 8'd7);
    @(posedge clk);
    last_edge = -1;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (e == 0) drive(1'b1, 1'b0, 8'd100, 8'd7);
      if (e == 2) drive(1'b1, 1'b1, 8'd50, 8'd5);
      if (e == 3) drive(1'b1, 1'b0, 8'd50, 8'd5);
      sample(1'b1, q, r, busy, done, dz, ov);
      if (done) begin
        last_edge = e;
        break;
      end
      @(posedge clk);
    end
    checks++;
    if (last_edge !== 9 || {q, r} !== {8'h0E, 8'h02}) begin
      errors++;
      $display("[TB] FAIL start_in_calc got edge=%0d q=%h r=%h want edge=9 q=0e r=02", last_edge, q, r);
    end
    check_op("restart_in_done", 1'b1, 8'd50, 8'd5);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = 8'h00;
      if ($urandom_range(0, 9) == 0) begin
        a = 8'h80;
        b = 8'hFF;
      end
      check_op("random", i[0], a, b);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1 test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
